// File: rtl/fcc_pkg.sv
// Shared types and constants for the flying-capacitor PWM modulator.
package fcc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fcc_state_e;

  // Gate bit positions inside each leg's 4-bit slice of pwm_o.
  localparam int unsigned S1A = 0;
  localparam int unsigned S1B = 1;
  localparam int unsigned S2A = 2;
  localparam int unsigned S2B = 3;

endpackage

// File: rtl/fcc_deadtime_cell.sv
// Dead-time insertion for one complementary gate pair.
// Any change of raw_i (or the first cycle after a clear) blanks both gates
// for DEADTIME cycles before the gate matching raw_i is asserted.
module fcc_deadtime_cell #(
  parameter int unsigned DEADTIME = 25
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic raw_i,
  output logic hi_o,
  output logic lo_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       prev_q;
  logic       armed_q;
  logic       restart;
  logic       quiet;

  // Blanking decision and counter next-state; outputs drop in the same cycle raw_i moves.
  always_comb begin
    restart = ~armed_q | (raw_i != prev_q);
    quiet   = ~clr_i & ~restart & (cnt_q == 8'd0);
    hi_o    = quiet & raw_i;
    lo_o    = quiet & ~raw_i;
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (restart) begin
      cnt_d = 8'(DEADTIME - 1);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Previous raw value, arm flag and blanking counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      if (clr_i) begin
        prev_q  <= 1'b0;
        armed_q <= 1'b0;
      end else begin
        prev_q  <= raw_i;
        armed_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fcc_pwm_modulator.sv
// Phase-shifted PWM modulator with dead-time for a 3-level flying-capacitor converter.
// Two triangle carriers 180 deg apart, valley-synchronous duty update, latched fault shutdown.
// Optional build macro FCC_PWM_SYNC_OUT_EN adds adc_trig_o, a 1-cycle pulse at the carrier peak.
module fcc_pwm_modulator
  import fcc_pkg::*;
#(
  parameter int unsigned N_LEGS   = 2,
  parameter int unsigned PERIOD   = 625,
  parameter int unsigned DUTY_W   = 12,
  parameter int unsigned DEADTIME = 25
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [N_LEGS*DUTY_W-1:0]   duty_i,
  input  logic                       duty_valid_i,
  input  logic                       fault_i,
  output logic [4*N_LEGS-1:0]        pwm_o,
  output logic                       fault_o,
  output logic                       valley_o
`ifdef FCC_PWM_SYNC_OUT_EN
  ,
  output logic                       adc_trig_o
`endif
);

  localparam int unsigned CW = $clog2(PERIOD + 1);

  fcc_state_e                         state_q, state_d;
  logic [CW-1:0]                      c1_q, c1_d;
  logic [CW-1:0]                      c2;
  logic                               up_q, up_d;
  logic [N_LEGS-1:0][DUTY_W-1:0]      pend_q, pend_d;
  logic [N_LEGS-1:0][CW-1:0]          act_q, act_d;
  logic [2*N_LEGS-1:0]                raw_q, raw_d;
  logic                               valley;
  logic                               clr;

  function automatic logic [CW-1:0] sat_duty(input logic [DUTY_W-1:0] d);
    if (d > DUTY_W'(PERIOD)) return CW'(PERIOD);
    return CW'(d);
  endfunction

  assign valley   = (state_q == RUN) && (c1_q == '0);
  assign clr      = (state_q != RUN);
  assign c2       = CW'(PERIOD) - c1_q;
  assign valley_o = valley;
  assign fault_o  = (state_q == FAULT);

`ifdef FCC_PWM_SYNC_OUT_EN
  assign adc_trig_o = (state_q == RUN) && (c1_q == CW'(PERIOD));
`endif

  // Mode FSM: fault has priority; leaving FAULT needs both enable and fault low.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fault_i)   state_d = FAULT;
        else if (en_i) state_d = RUN;
      end
      RUN: begin
        if (fault_i)    state_d = FAULT;
        else if (!en_i) state_d = IDLE;
      end
      FAULT: begin
        if (!en_i && !fault_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Up/down carrier; parked at 0 counting up whenever not running, so RUN always starts at a valley.
  always_comb begin
    c1_d = '0;
    up_d = 1'b1;
    if (state_q == RUN && state_d == RUN) begin
      if (up_q) begin
        if (c1_q == CW'(PERIOD)) begin
          c1_d = CW'(PERIOD - 1);
          up_d = 1'b0;
        end else begin
          c1_d = c1_q + 1'b1;
        end
      end else begin
        if (c1_q == '0) begin
          c1_d = CW'(1);
        end else begin
          c1_d = c1_q - 1'b1;
          up_d = 1'b0;
        end
      end
    end
  end

  // Duty pipeline: pending is written on strobe, active takes the old pending at valleys or on start.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    if (valley || (state_q == IDLE && state_d == RUN)) begin
      for (int k = 0; k < N_LEGS; k++) act_d[k] = sat_duty(pend_q[k]);
    end
    if (duty_valid_i) begin
      for (int k = 0; k < N_LEGS; k++) pend_d[k] = duty_i[k*DUTY_W +: DUTY_W];
    end
  end

  // Raw references; full-scale duty must hold high even at the carrier peak.
  always_comb begin
    raw_d = '0;
    if (state_q == RUN) begin
      for (int k = 0; k < N_LEGS; k++) begin
        raw_d[2*k]   = (act_q[k] == CW'(PERIOD)) || (act_q[k] > c1_q);
        raw_d[2*k+1] = (act_q[k] == CW'(PERIOD)) || (act_q[k] > c2);
      end
    end
  end

  // State, carrier, duty and raw-reference registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      c1_q    <= '0;
      up_q    <= 1'b1;
      pend_q  <= '0;
      act_q   <= '0;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      c1_q    <= c1_d;
      up_q    <= up_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      raw_q   <= raw_d;
    end
  end

  for (genvar k = 0; k < N_LEGS; k++) begin : g_leg
    fcc_deadtime_cell #(
      .DEADTIME (DEADTIME)
    ) u_dt_s1 (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr),
      .raw_i  (raw_q[2*k]),
      .hi_o   (pwm_o[4*k+S1A]),
      .lo_o   (pwm_o[4*k+S1B])
    );

    fcc_deadtime_cell #(
      .DEADTIME (DEADTIME)
    ) u_dt_s2 (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr),
      .raw_i  (raw_q[2*k+1]),
      .hi_o   (pwm_o[4*k+S2A]),
      .lo_o   (pwm_o[4*k+S2B])
    );
  end

endmodule
